// File: rtl/text_pixel_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | text_pixel_gen_if : pixel stream valid/ready bundle                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface text_pixel_gen_if;
    logic pix_valid;
    logic pix_ready;
    logic pix_data;
    logic pix_last;

    modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
    modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);
endinterface
`default_nettype wire

// File: rtl/text_pixel_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | text_pixel_gen : text-mode raster renderer feeding FontRom         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module text_pixel_gen #(
    parameter int COLS   = 16,
    parameter int ROWS   = 4,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [13:0]       rom_ad,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    input  logic              rom_dout,
    text_pixel_gen_if.master  pix
);
    localparam int                X_W   = $clog2(COLS * 8);
    localparam int                Y_W   = $clog2(ROWS * 16);
    localparam int                CELLS = COLS * ROWS;
    localparam logic [X_W-1:0]    X_MAX = X_W'(COLS * 8 - 1);
    localparam logic [Y_W-1:0]    Y_MAX = Y_W'(ROWS * 16 - 1);
    localparam logic [ADDR_W:0]   CELLS_LIM = (ADDR_W + 1)'(CELLS);

    logic [7:0] mem [CELLS];

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           run_q, run_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]     rd_q, rd_d;
    logic [3:0]     row1_q, row1_d;
    logic [2:0]     col1_q, col1_d;
    logic           v1_q, v1_d, last1_q, last1_d;
    logic [13:0]    ad_q, ad_d;
    logic           inv2_q, inv2_d, v2_q, v2_d, last2_q, last2_d;
    logic           pv_q, pv_d, pl_q, pl_d, inv3_q, inv3_d;

    logic              w_stall, w_start_ok, w_s0_last, w_last_hs;
    logic [ADDR_W-1:0] w_rd_addr;

    always_comb begin
        w_stall    = pv_q && !pix.pix_ready;
        w_start_ok = start && !busy_q;
        w_s0_last  = (x_q == X_MAX) && (y_q == Y_MAX);
        w_last_hs  = pv_q && pix.pix_ready && pl_q;
        w_rd_addr  = ADDR_W'(y_q[Y_W-1:4]) * ADDR_W'(COLS) + ADDR_W'(x_q[X_W-1:3]);
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        run_d   = run_q;
        busy_d  = busy_q;
        done_d  = w_last_hs;
        rd_d    = rd_q;
        row1_d  = row1_q;
        col1_d  = col1_q;
        v1_d    = v1_q;
        last1_d = last1_q;
        ad_d    = ad_q;
        inv2_d  = inv2_q;
        v2_d    = v2_q;
        last2_d = last2_q;
        pv_d    = pv_q;
        pl_d    = pl_q;
        inv3_d  = inv3_q;

        if (w_last_hs) begin
            busy_d = 1'b0;
        end
        if (w_start_ok) begin
            busy_d = 1'b1;
            run_d  = 1'b1;
            x_d    = '0;
            y_d    = '0;
        end

        // Whole pipeline freezes on stall so the ROM output and inverse bit stay aligned.
        if (!w_stall) begin
            rd_d    = mem[w_rd_addr];
            row1_d  = y_q[3:0];
            col1_d  = x_q[2:0];
            v1_d    = run_q;
            last1_d = run_q && w_s0_last;
            ad_d    = {rd_q[6:0], row1_q, col1_q};
            inv2_d  = rd_q[7];
            v2_d    = v1_q;
            last2_d = last1_q;
            pv_d    = v2_q;
            pl_d    = last2_q;
            inv3_d  = inv2_q;
            if (run_q) begin
                if (w_s0_last) begin
                    run_d = 1'b0;
                    x_d   = '0;
                    y_d   = '0;
                end else if (x_q == X_MAX) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= '0;
            row1_q  <= '0;
            col1_q  <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            ad_q    <= '0;
            inv2_q  <= 1'b0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            pv_q    <= 1'b0;
            pl_q    <= 1'b0;
            inv3_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            row1_q  <= row1_d;
            col1_q  <= col1_d;
            v1_q    <= v1_d;
            last1_q <= last1_d;
            ad_q    <= ad_d;
            inv2_q  <= inv2_d;
            v2_q    <= v2_d;
            last2_q <= last2_d;
            pv_q    <= pv_d;
            pl_q    <= pl_d;
            inv3_q  <= inv3_d;
        end
    end

    // Read-first: the registered read above samples the old word on a same-index write.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < CELLS_LIM)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign rom_ad        = ad_q;
    assign rom_ce        = v2_q && !w_stall;
    assign rom_oce       = 1'b1;
    assign rom_reset     = 1'b0;
    assign pix.pix_valid = pv_q;
    assign pix.pix_last  = pl_q;
    assign pix.pix_data  = rom_dout ^ inv3_q;
endmodule
`default_nettype wire

// File: tb/tb_text_pixel_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_text_pixel_gen : self-checking bench for text_pixel_gen         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_text_pixel_gen;
    localparam int COLS   = 16;
    localparam int ROWS   = 4;
    localparam int ADDR_W = 6;
    localparam int W      = COLS * 8;
    localparam int NPIX   = COLS * 8 * ROWS * 16;
    localparam int BUDGET = 40000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, frame_done;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic [13:0]       rom_ad;
    logic              rom_ce, rom_oce, rom_reset;
    logic              rom_dout = 1'b0;

    text_pixel_gen_if pix();

    text_pixel_gen #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset),
        .rom_dout(rom_dout), .pix(pix.master)
    );

    always #5 clk = ~clk;

    // FontRom stand-in: code 0 is a blank glyph, other codes a fixed pseudo-random bitmap.
    function automatic bit font(input logic [13:0] a);
        logic [31:0] v;
        if (a[13:7] == 7'd0) return 1'b0;
        v = {18'd0, a} * 32'd1103515245 + 32'd12345;
        return v[16] ^ v[23];
    endfunction

    always @(posedge clk) if (rom_ce) rom_dout <= font(rom_ad);

    logic [7:0] buf_m [COLS*ROWS];

    function automatic bit exp_pix(input int i);
        int x, y, c, a;
        y = i / W;
        x = i % W;
        c = int'(buf_m[(y / 16) * COLS + x / 8]);
        a = (c % 128) * 128 + (y % 16) * 8 + (x % 8);
        return font(14'(a)) ^ c[7];
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input bit rnd, input logic [7:0] fillb, input logic [7:0] idx0);
        for (int i = 0; i < COLS * ROWS; i++) begin
            logic [7:0] d;
            d = rnd ? 8'($urandom) : ((i == 0) ? idx0 : fillb);
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(i);
            wr_data = d;
            buf_m[i] = d;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    int          got_n, mism, ones, last_cnt, last_idx, lat, stab_err, busy_err;
    logic [13:0] first_ad;

    // Starts at a negedge; returns at the negedge after the last handshake (or right after
    // asserting rst_n when abort_at is reached).
    task automatic run_frame(input int rdy_pct, input bit mid_start, input bit last_start,
                             input int abort_at);
        bit done, prev_stall, prev_d, prev_l;
        int k;
        done = 0; prev_stall = 0; prev_d = 0; prev_l = 0; k = 0;
        got_n = 0; mism = 0; ones = 0; last_cnt = 0; last_idx = -1; lat = -1;
        stab_err = 0; busy_err = 0; first_ad = '1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            if (k == 2) first_ad = rom_ad;
            if (pix.pix_valid && lat < 0) lat = k;
            if (abort_at >= 0 && got_n == abort_at) begin
                rst_n = 1'b0;
                done  = 1;
            end else begin
                pix.pix_ready = ($urandom_range(99) < rdy_pct);
                if (prev_stall && (pix.pix_valid !== 1'b1 || pix.pix_data !== prev_d ||
                                   pix.pix_last !== prev_l)) stab_err++;
                if (busy !== 1'b1) busy_err++;
                if (pix.pix_valid && pix.pix_ready) begin
                    if (mid_start && got_n == 100) start = 1'b1;
                    if (last_start && pix.pix_last) start = 1'b1;
                    if (got_n >= NPIX || pix.pix_data !== exp_pix(got_n)) mism++;
                    ones += int'(pix.pix_data);
                    if (pix.pix_last) begin
                        last_cnt++;
                        last_idx = got_n;
                        done = 1;
                    end
                    got_n++;
                end
                prev_stall = pix.pix_valid && !pix.pix_ready;
                prev_d     = pix.pix_data;
                prev_l     = pix.pix_last;
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                k++;
            end
        end
    endtask

    task automatic frame_checks(input string tag, input logic [13:0] exp_ad, input int exp_ones);
        check({tag, " pixel_count"}, got_n, NPIX);
        check({tag, " pixel_mismatches"}, mism, 0);
        check({tag, " last_count"}, last_cnt, 1);
        check({tag, " last_index"}, last_idx, NPIX - 1);
        check({tag, " stall_unstable"}, stab_err, 0);
        check({tag, " busy_low_in_frame"}, busy_err, 0);
        check({tag, " latency"}, lat, 3);
        check({tag, " first_rom_ad"}, first_ad, exp_ad);
        check({tag, " frame_done"}, frame_done, 1);
        check({tag, " busy_after"}, busy, 0);
        if (exp_ones >= 0) check({tag, " ones"}, ones, exp_ones);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " pix_valid"}, pix.pix_valid, 0);
        check({tag, " pix_last"}, pix.pix_last, 0);
        check({tag, " rom_ce"}, rom_ce, 0);
        check({tag, " rom_ad"}, rom_ad, 0);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  fillb;
        logic [7:0]  idx0;
        int          rdy_pct;
        logic [13:0] exp_ad;
        int          exp_ones;   // -1: pixel content judged by the model only
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{"zeros",      8'h00, 8'h00, 100, 14'h0000, 0};
        vecs[1] = '{"inverse",    8'h80, 8'h80, 100, 14'h0000, NPIX};
        vecs[2] = '{"glyph41",    8'h00, 8'h41, 100, 14'h2080, -1};
        vecs[3] = '{"glyph41_rdy", 8'h00, 8'h41, 50, 14'h2080, -1};

        pix.pix_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        check("rom_oce", rom_oce, 1);
        check("rom_reset", rom_reset, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            fill(0, vecs[v].fillb, vecs[v].idx0);
            run_frame(vecs[v].rdy_pct, 0, 0, -1);
            frame_checks(vecs[v].name, vecs[v].exp_ad, vecs[v].exp_ones);
            @(negedge clk);
            check({vecs[v].name, " done_pulse_width"}, frame_done, 0);
        end

        // Starts mid-frame and on the last handshake are ignored; one on frame_done begins a frame.
        fill(1, 8'h00, 8'h00);
        run_frame(100, 1, 1, -1);
        frame_checks("restart_ignored", {buf_m[0][6:0], 7'd0}, -1);
        run_frame(70, 0, 0, -1);
        frame_checks("restart_on_done", {buf_m[0][6:0], 7'd0}, -1);
        @(negedge clk);
        check("restart done_pulse_width", frame_done, 0);

        // Mid-frame reset abort, then a fresh full frame.
        fill(1, 8'h00, 8'h00);
        run_frame(100, 0, 0, 4000);
        check("abort pixels_before_reset", got_n, 4000);
        @(posedge clk);
        @(negedge clk);
        reset_checks("abort");
        rst_n = 1'b1;
        @(negedge clk);
        check("abort no_frame_done", frame_done, 0);
        fill(1, 8'h00, 8'h00);
        run_frame(85, 0, 0, -1);
        frame_checks("after_reset", {buf_m[0][6:0], 7'd0}, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
